// File: rtl/mmio_fabric.sv
// ============================================================================
//  Module      : mmio_fabric
//  Description : Mask/base decoded MMIO interconnect with registered read
//                response, no-response timeout and sticky bus-error capture.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_fabric #(
  parameter int                           N_SLAVES   = 4,
  parameter int                           DATA_W     = 32,
  parameter int                           ADDR_W     = 32,
  parameter logic [N_SLAVES*ADDR_W-1:0]   SLAVE_BASE = {32'h408, 32'h404, 32'h400, 32'h100},
  parameter logic [N_SLAVES*ADDR_W-1:0]   SLAVE_MASK = {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFF00},
  parameter int                           TIMEOUT    = 255,
  parameter logic [DATA_W-1:0]            ERR_DATA   = 32'hDEADBEEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_en,
  input  logic                         mem_read,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DATA_W-1:0]            wdata,
  output logic [DATA_W-1:0]            rdata,
  output logic                         read_ack,
  output logic [N_SLAVES-1:0]          slave_en,
  output logic                         slave_read,
  output logic [ADDR_W-1:0]            slave_addr,
  output logic [DATA_W-1:0]            slave_wdata,
  input  logic [N_SLAVES*DATA_W-1:0]   slave_rdata,
  input  logic [N_SLAVES-1:0]          slave_ack,
  output logic                         err_valid,
  output logic [ADDR_W-1:0]            err_addr,
  input  logic                         err_clear
);

  localparam int c_idx_w = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int c_cnt_w = $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_expire = c_cnt_w'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_ACK = 2'd1,
    S_RESP     = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [c_idx_w-1:0]   r_idx;
  logic                 r_miss;
  logic [ADDR_W-1:0]    r_addr;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [DATA_W-1:0]    r_rdata;
  logic                 r_read_ack;
  logic                 r_err_valid;
  logic [ADDR_W-1:0]    r_err_addr;

  logic [N_SLAVES-1:0]  w_hit;
  logic                 w_hit_any;
  logic [c_idx_w-1:0]   w_hit_idx;
  logic                 w_sel_ack;
  logic [DATA_W-1:0]    w_sel_rdata;
  logic                 w_expired;
  logic                 w_rd_req;
  logic                 w_resp_ok;
  logic                 w_resp_err;
  logic                 w_err_wr;
  logic                 w_err_set;
  logic [ADDR_W-1:0]    w_err_at;

  genvar gi;
  generate
    for (gi = 0; gi < N_SLAVES; gi++) begin : g_decode
      assign w_hit[gi] = ((addr & SLAVE_MASK[gi*ADDR_W +: ADDR_W]) == SLAVE_BASE[gi*ADDR_W +: ADDR_W]);
    end
  endgenerate

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    w_hit_any = 1'b0;
    w_hit_idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_hit_any = 1'b1;
        w_hit_idx = c_idx_w'(i);
      end
    end
  end

  always_comb begin
    w_sel_ack   = 1'b0;
    w_sel_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (r_idx == c_idx_w'(i)) begin
        w_sel_ack   = slave_ack[i] && !r_miss;
        w_sel_rdata = slave_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_expired  = (r_cnt == c_expire);
  assign w_rd_req   = (r_state == S_IDLE) && mem_en && mem_read;
  // An abort (mem_en low) takes precedence over both ack and expiry.
  assign w_resp_ok  = (r_state == S_WAIT_ACK) && mem_en && w_sel_ack;
  assign w_resp_err = (r_state == S_WAIT_ACK) && mem_en && !w_sel_ack && w_expired;
  assign w_err_wr   = (r_state == S_IDLE) && mem_en && !mem_read && !w_hit_any;
  assign w_err_set  = w_err_wr || w_resp_err;
  assign w_err_at   = w_err_wr ? addr : r_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    slave_en = '0;
    case (r_state)
      S_IDLE: begin
        if (mem_en && mem_read) begin
          w_next = S_WAIT_ACK;
        end else if (mem_en && w_hit_any) begin
          slave_en = N_SLAVES'(1) << w_hit_idx;
        end
      end
      S_WAIT_ACK: begin
        if (!mem_en) begin
          w_next = S_IDLE;
        end else begin
          if (!r_miss) begin
            slave_en = N_SLAVES'(1) << r_idx;
          end
          if (w_sel_ack || w_expired) begin
            w_next = S_RESP;
          end
        end
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= '0;
      r_miss      <= 1'b0;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_read_ack  <= 1'b0;
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
    end else begin
      r_read_ack <= w_resp_ok || w_resp_err;
      if (w_resp_ok) begin
        r_rdata <= w_sel_rdata;
      end else if (w_resp_err) begin
        r_rdata <= ERR_DATA;
      end

      if (w_rd_req) begin
        r_idx  <= w_hit_idx;
        r_miss <= !w_hit_any;
        r_addr <= addr;
        r_cnt  <= '0;
      end else if ((r_state == S_WAIT_ACK) && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end

      // A new fault beats a simultaneous clear and re-arms with its address.
      if (w_err_set) begin
        if (!r_err_valid || err_clear) begin
          r_err_valid <= 1'b1;
          r_err_addr  <= w_err_at;
        end
      end else if (err_clear) begin
        r_err_valid <= 1'b0;
      end
    end
  end

  assign rdata       = r_rdata;
  assign read_ack    = r_read_ack;
  assign slave_read  = mem_read;
  assign slave_addr  = addr;
  assign slave_wdata = wdata;
  assign err_valid   = r_err_valid;
  assign err_addr    = r_err_addr;

endmodule

`default_nettype wire

// File: tb/tb_mmio_fabric.sv
// ============================================================================
//  Module      : tb_mmio_fabric
//  Description : Directed self-checking bench for mmio_fabric.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmio_fabric;

  logic         clk;
  logic         rst;
  logic         mem_en;
  logic         mem_read;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic         read_ack;
  logic [3:0]   slave_en;
  logic         slave_read;
  logic [31:0]  slave_addr;
  logic [31:0]  slave_wdata;
  logic [127:0] slave_rdata;
  logic [3:0]   slave_ack;
  logic         err_valid;
  logic [31:0]  err_addr;
  logic         err_clear;

  int n_pass;
  int n_total;

  mmio_fabric dut (
    .clk         (clk),
    .rst         (rst),
    .mem_en      (mem_en),
    .mem_read    (mem_read),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .read_ack    (read_ack),
    .slave_en    (slave_en),
    .slave_read  (slave_read),
    .slave_addr  (slave_addr),
    .slave_wdata (slave_wdata),
    .slave_rdata (slave_rdata),
    .slave_ack   (slave_ack),
    .err_valid   (err_valid),
    .err_addr    (err_addr),
    .err_clear   (err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b1; mem_en = 1'b0; mem_read = 1'b0; addr = '0; wdata = '0;
    slave_rdata = '0; slave_ack = '0; err_clear = 1'b0;
    tick(); tick();
    chk("rst_read_ack", 64'(read_ack), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_slave_en", 64'(slave_en), 64'd0);
    chk("rst_err_valid", 64'(err_valid), 64'd0);
    chk("rst_err_addr", 64'(err_addr), 64'd0);
    rst = 1'b0;
    tick();

    // Read 0x104, slave0 acks in the third wait cycle.
    mem_en = 1'b1; mem_read = 1'b1; addr = 32'h104; #1;
    chk("rd0_idle_en", 64'(slave_en), 64'd0);
    tick();
    chk("rd0_wait_en", 64'(slave_en), 64'b0001);
    tick(); tick();
    slave_ack = 4'b0001; slave_rdata[31:0] = 32'h12345678; #1;
    chk("rd0_no_ack_yet", 64'(read_ack), 64'd0);
    tick();
    slave_ack = '0; mem_en = 1'b0;
    chk("rd0_read_ack", 64'(read_ack), 64'd1);
    chk("rd0_rdata", 64'(rdata), 64'h12345678);
    chk("rd0_resp_en", 64'(slave_en), 64'd0);
    chk("rd0_err", 64'(err_valid), 64'd0);
    tick();
    chk("rd0_ack_drop", 64'(read_ack), 64'd0);
    chk("rd0_rdata_hold", 64'(rdata), 64'h12345678);

    // Posted writes: 0x400 then 0x404 on consecutive cycles.
    mem_en = 1'b1; mem_read = 1'b0; addr = 32'h400; wdata = 32'h1F; #1;
    chk("wr_en_s1", 64'(slave_en), 64'b0010);
    chk("wr_wdata", 64'(slave_wdata), 64'h1F);
    chk("wr_read", 64'(slave_read), 64'd0);
    tick();
    addr = 32'h404; #1;
    chk("wr_en_s2_idle", 64'(slave_en), 64'b0100);
    chk("wr_no_ack", 64'(read_ack), 64'd0);
    tick();
    mem_en = 1'b0; #1;
    chk("wr_en_off", 64'(slave_en), 64'd0);

    // Unmapped read 0x800 times out.
    mem_en = 1'b1; mem_read = 1'b1; addr = 32'h800;
    tick();
    chk("miss_en", 64'(slave_en), 64'd0);
    repeat (254) tick();
    chk("miss_pre_ack", 64'(read_ack), 64'd0);
    tick();
    mem_en = 1'b0;
    chk("miss_ack", 64'(read_ack), 64'd1);
    chk("miss_rdata", 64'(rdata), 64'hDEADBEEF);
    chk("miss_err", 64'(err_valid), 64'd1);
    chk("miss_err_addr", 64'(err_addr), 64'h800);
    tick();
    mem_en = 1'b1; mem_read = 1'b0; addr = 32'h900; #1;
    chk("wr900_en", 64'(slave_en), 64'd0);
    tick();
    mem_en = 1'b0;
    chk("wr900_sticky", 64'(err_addr), 64'h800);

    // Slave3 silent; other slaves acking must be ignored.
    slave_ack = 4'b0111;
    mem_en = 1'b1; mem_read = 1'b1; addr = 32'h408;
    tick();
    chk("s3_en", 64'(slave_en), 64'b1000);
    repeat (254) tick();
    tick();
    mem_en = 1'b0; slave_ack = '0;
    chk("s3_to_ack", 64'(read_ack), 64'd1);
    chk("s3_to_rdata", 64'(rdata), 64'hDEADBEEF);
    chk("s3_to_err_addr", 64'(err_addr), 64'h800);
    tick();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("clear", 64'(err_valid), 64'd0);

    // Ack lands exactly on the expiry cycle.
    mem_en = 1'b1; mem_read = 1'b1; addr = 32'h408;
    tick();
    repeat (254) tick();
    slave_ack = 4'b1000; slave_rdata[127:96] = 32'hCAFEF00D;
    tick();
    mem_en = 1'b0; slave_ack = '0;
    chk("exp_ack", 64'(read_ack), 64'd1);
    chk("exp_rdata", 64'(rdata), 64'hCAFEF00D);
    chk("exp_no_err", 64'(err_valid), 64'd0);
    tick();

    // Clear racing a new unmapped write.
    mem_en = 1'b1; mem_read = 1'b0; addr = 32'h900;
    tick();
    chk("wr900_err", 64'(err_addr), 64'h900);
    addr = 32'hA00; err_clear = 1'b1;
    tick();
    mem_en = 1'b0; err_clear = 1'b0;
    chk("race_valid", 64'(err_valid), 64'd1);
    chk("race_addr", 64'(err_addr), 64'hA00);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("race_clear", 64'(err_valid), 64'd0);

    // Reset in the middle of a wait.
    mem_en = 1'b1; mem_read = 1'b1; addr = 32'h104;
    tick(); tick();
    rst = 1'b1; mem_en = 1'b0;
    tick();
    rst = 1'b0; slave_ack = 4'b0001; slave_rdata[31:0] = 32'h0BAD0BAD; #1;
    chk("rst_mid_en", 64'(slave_en), 64'd0);
    chk("rst_mid_ack", 64'(read_ack), 64'd0);
    chk("rst_mid_rdata", 64'(rdata), 64'd0);
    tick();
    chk("rst_late_ack", 64'(read_ack), 64'd0);
    slave_ack = '0;

    // CPU abort in the middle of a wait.
    mem_en = 1'b1; mem_read = 1'b1; addr = 32'h104;
    tick(); tick();
    mem_en = 1'b0;
    tick();
    slave_ack = 4'b0001; #1;
    chk("abort_en", 64'(slave_en), 64'd0);
    chk("abort_ack", 64'(read_ack), 64'd0);
    tick();
    chk("abort_late_ack", 64'(read_ack), 64'd0);
    chk("abort_no_err", 64'(err_valid), 64'd0);
    slave_ack = '0;

    // Zero-wait read afterwards: read_ack two cycles after acceptance.
    mem_en = 1'b1; mem_read = 1'b1; addr = 32'h1FC;
    tick();
    slave_ack = 4'b0001; slave_rdata[31:0] = 32'h000055AA; #1;
    chk("zw_wait_en", 64'(slave_en), 64'b0001);
    tick();
    mem_en = 1'b0; slave_ack = '0;
    chk("zw_ack", 64'(read_ack), 64'd1);
    chk("zw_rdata", 64'(rdata), 64'h55AA);
    tick();
    chk("zw_ack_drop", 64'(read_ack), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
